// File: rtl/tabla_run_controller.sv
// Run sequencer for the Tabla datapath: drives the RD -> PR -> WR iteration loop
// and exposes sticky status flags plus saturating per-phase cycle counters.
module tabla_run_controller #(
  parameter int PERF_CNTR_WIDTH = 32,
  parameter int ITER_WIDTH      = 16
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       start,
  input  logic                       abort,
  input  logic [ITER_WIDTH-1:0]      num_iters,
  output logic                       tx_req,
  input  logic                       rd_ack,
  output logic                       pr_start,
  input  logic                       pr_done,
  output logic                       wr_req,
  input  logic                       wr_ack,
  output logic                       busy,
  output logic                       tx_done,
  output logic                       rd_done,
  output logic                       processing_done,
  output logic                       wr_done,
  output logic                       aborted,
  output logic [ITER_WIDTH-1:0]      iter_count,
  output logic [PERF_CNTR_WIDTH-1:0] total_cycles,
  output logic [PERF_CNTR_WIDTH-1:0] rd_cycles,
  output logic [PERF_CNTR_WIDTH-1:0] pr_cycles,
  output logic [PERF_CNTR_WIDTH-1:0] wr_cycles
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_PR   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [PERF_CNTR_WIDTH-1:0] CNT_ONE  = {{(PERF_CNTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PERF_CNTR_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [ITER_WIDTH-1:0]      ITER_ONE = {{(ITER_WIDTH-1){1'b0}}, 1'b1};

  state_t                     state_q, state_d;
  logic [ITER_WIDTH-1:0]      target_q, target_d;
  logic [ITER_WIDTH-1:0]      iter_q, iter_d;
  logic [ITER_WIDTH-1:0]      iter_next;
  logic                       last_iter;
  logic [PERF_CNTR_WIDTH-1:0] rd_cyc_q, rd_cyc_d;
  logic [PERF_CNTR_WIDTH-1:0] pr_cyc_q, pr_cyc_d;
  logic [PERF_CNTR_WIDTH-1:0] wr_cyc_q, wr_cyc_d;
  logic [PERF_CNTR_WIDTH-1:0] tot_cyc_q, tot_cyc_d;
  logic                       tx_req_q, tx_req_d;
  logic                       wr_req_q, wr_req_d;
  logic                       busy_q, busy_d;
  logic                       pr_start_q, pr_start_d;
  logic                       tx_done_q, tx_done_d;
  logic                       rd_done_q, rd_done_d;
  logic                       proc_done_q, proc_done_d;
  logic                       wr_done_q, wr_done_d;
  logic                       aborted_q, aborted_d;

  assign iter_next = iter_q + ITER_ONE;
  assign last_iter = (iter_next == target_q);

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    iter_d      = iter_q;
    pr_start_d  = 1'b0;
    tx_done_d   = tx_done_q;
    rd_done_d   = rd_done_q;
    proc_done_d = proc_done_q;
    wr_done_d   = wr_done_q;
    aborted_d   = aborted_q;
    rd_cyc_d    = rd_cyc_q;
    pr_cyc_d    = pr_cyc_q;
    wr_cyc_d    = wr_cyc_q;
    tot_cyc_d   = tot_cyc_q;

    // Every cycle spent in a phase counts, including the ack or abort cycle.
    if (state_q == S_RD && !(&rd_cyc_q)) rd_cyc_d = rd_cyc_q + CNT_ONE;
    if (state_q == S_PR && !(&pr_cyc_q)) pr_cyc_d = pr_cyc_q + CNT_ONE;
    if (state_q == S_WR && !(&wr_cyc_q)) wr_cyc_d = wr_cyc_q + CNT_ONE;
    if ((state_q == S_RD || state_q == S_PR || state_q == S_WR) && !(&tot_cyc_q))
      tot_cyc_d = tot_cyc_q + CNT_ONE;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          state_d     = S_RD;
          target_d    = (num_iters == '0) ? ITER_ONE : num_iters;
          iter_d      = '0;
          tx_done_d   = 1'b0;
          rd_done_d   = 1'b0;
          proc_done_d = 1'b0;
          wr_done_d   = 1'b0;
          aborted_d   = 1'b0;
          rd_cyc_d    = CNT_ZERO;
          pr_cyc_d    = CNT_ZERO;
          wr_cyc_d    = CNT_ZERO;
          tot_cyc_d   = CNT_ZERO;
        end
      end
      S_RD: begin
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (rd_ack) begin
          state_d    = S_PR;
          pr_start_d = 1'b1;
          if (last_iter) rd_done_d = 1'b1;
        end
      end
      S_PR: begin
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (pr_done) begin
          state_d = S_WR;
          if (last_iter) proc_done_d = 1'b1;
        end
      end
      S_WR: begin
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (wr_ack) begin
          iter_d = iter_next;
          if (last_iter) begin
            state_d   = S_DONE;
            wr_done_d = 1'b1;
            tx_done_d = 1'b1;
          end else begin
            state_d = S_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    tx_req_d = (state_d == S_RD);
    wr_req_d = (state_d == S_WR);
    busy_d   = (state_d == S_RD) || (state_d == S_PR) || (state_d == S_WR);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      target_q    <= ITER_ONE;
      iter_q      <= '0;
      rd_cyc_q    <= '0;
      pr_cyc_q    <= '0;
      wr_cyc_q    <= '0;
      tot_cyc_q   <= '0;
      tx_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      pr_start_q  <= 1'b0;
      tx_done_q   <= 1'b0;
      rd_done_q   <= 1'b0;
      proc_done_q <= 1'b0;
      wr_done_q   <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      iter_q      <= iter_d;
      rd_cyc_q    <= rd_cyc_d;
      pr_cyc_q    <= pr_cyc_d;
      wr_cyc_q    <= wr_cyc_d;
      tot_cyc_q   <= tot_cyc_d;
      tx_req_q    <= tx_req_d;
      wr_req_q    <= wr_req_d;
      busy_q      <= busy_d;
      pr_start_q  <= pr_start_d;
      tx_done_q   <= tx_done_d;
      rd_done_q   <= rd_done_d;
      proc_done_q <= proc_done_d;
      wr_done_q   <= wr_done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign tx_req          = tx_req_q;
  assign wr_req          = wr_req_q;
  assign busy            = busy_q;
  assign pr_start        = pr_start_q;
  assign tx_done         = tx_done_q;
  assign rd_done         = rd_done_q;
  assign processing_done = proc_done_q;
  assign wr_done         = wr_done_q;
  assign aborted         = aborted_q;
  assign iter_count      = iter_q;
  assign total_cycles    = tot_cyc_q;
  assign rd_cycles       = rd_cyc_q;
  assign pr_cycles       = pr_cyc_q;
  assign wr_cycles       = wr_cyc_q;

endmodule

// File: tb/tb_tabla_run_controller.sv
// Directed bench for tabla_run_controller: a 32-bit counter instance for the
// run/abort/reset scenarios and a 4-bit counter instance for saturation.
module tb_tabla_run_controller;

  logic        ACLK;
  logic        ARESETN;
  logic        abort;
  logic        start, rd_ack, pr_done, wr_ack;
  logic [15:0] num_iters;
  logic        tx_req, pr_start, wr_req, busy;
  logic        tx_done, rd_done, processing_done, wr_done, aborted;
  logic [15:0] iter_count;
  logic [31:0] total_cycles, rd_cycles, pr_cycles, wr_cycles;

  logic        s_start, s_rd_ack, s_pr_done, s_wr_ack;
  logic [15:0] s_num_iters;
  logic        s_tx_req, s_pr_start, s_wr_req, s_busy;
  logic        s_tx_done, s_rd_done, s_processing_done, s_wr_done, s_aborted;
  logic [15:0] s_iter_count;
  logic [3:0]  s_total_cycles, s_rd_cycles, s_pr_cycles, s_wr_cycles;

  int vecs = 0;
  int errs = 0;

  tabla_run_controller #(.PERF_CNTR_WIDTH(32), .ITER_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .abort(abort), .num_iters(num_iters),
    .tx_req(tx_req), .rd_ack(rd_ack), .pr_start(pr_start), .pr_done(pr_done),
    .wr_req(wr_req), .wr_ack(wr_ack), .busy(busy), .tx_done(tx_done), .rd_done(rd_done),
    .processing_done(processing_done), .wr_done(wr_done), .aborted(aborted),
    .iter_count(iter_count), .total_cycles(total_cycles), .rd_cycles(rd_cycles),
    .pr_cycles(pr_cycles), .wr_cycles(wr_cycles)
  );

  tabla_run_controller #(.PERF_CNTR_WIDTH(4), .ITER_WIDTH(16)) dut_s (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(s_start), .abort(abort), .num_iters(s_num_iters),
    .tx_req(s_tx_req), .rd_ack(s_rd_ack), .pr_start(s_pr_start), .pr_done(s_pr_done),
    .wr_req(s_wr_req), .wr_ack(s_wr_ack), .busy(s_busy), .tx_done(s_tx_done),
    .rd_done(s_rd_done), .processing_done(s_processing_done), .wr_done(s_wr_done),
    .aborted(s_aborted), .iter_count(s_iter_count), .total_cycles(s_total_cycles),
    .rd_cycles(s_rd_cycles), .pr_cycles(s_pr_cycles), .wr_cycles(s_wr_cycles)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_ack(input int which, input bit s, input logic v);
    if (s) begin
      if (which == 0) s_rd_ack = v; else if (which == 1) s_pr_done = v; else s_wr_ack = v;
    end else begin
      if (which == 0) rd_ack = v; else if (which == 1) pr_done = v; else wr_ack = v;
    end
  endtask

  // Stay n cycles in the current phase, pulsing its ack during the n-th cycle.
  task automatic run_phase(input int n, input int which, input bit s);
    repeat (n - 1) step();
    set_ack(which, s, 1'b1);
    step();
    set_ack(which, s, 1'b0);
  endtask

  task automatic do_start(input logic [15:0] n);
    num_iters = n;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  initial begin
    ARESETN = 1'b0; abort = 1'b0;
    start = 1'b0; rd_ack = 1'b0; pr_done = 1'b0; wr_ack = 1'b0; num_iters = '0;
    s_start = 1'b0; s_rd_ack = 1'b0; s_pr_done = 1'b0; s_wr_ack = 1'b0; s_num_iters = '0;
    repeat (3) step();

    check("rst_busy", busy, 0);
    check("rst_tx_req", tx_req, 0);
    check("rst_flags", {tx_done, rd_done, processing_done, wr_done, aborted, pr_start, wr_req}, 0);
    check("rst_total", total_cycles, 0);
    check("rst_iter", iter_count, 0);
    ARESETN = 1'b1;
    step();

    // Run 1: one iteration, RD 5 / PR 10 / WR 3 cycles.
    do_start(16'd1);
    check("t1_tx_req", tx_req, 1);
    check("t1_busy", busy, 1);
    run_phase(5, 0, 1'b0);
    check("t1_pr_start", pr_start, 1);
    check("t1_tx_req_drop", tx_req, 0);
    step();
    check("t1_pr_start_pulse", pr_start, 0);
    run_phase(9, 1, 1'b0);
    check("t1_wr_req", wr_req, 1);
    run_phase(3, 2, 1'b0);
    check("t1_rd_cycles", rd_cycles, 5);
    check("t1_pr_cycles", pr_cycles, 10);
    check("t1_wr_cycles", wr_cycles, 3);
    check("t1_total", total_cycles, 18);
    check("t1_done_flags", {tx_done, rd_done, processing_done, wr_done}, 4'b1111);
    check("t1_iter", iter_count, 1);
    check("t1_idle", {busy, wr_req, tx_req}, 0);
    step();
    check("t1_hold_total", total_cycles, 18);
    $display("run 1: total=%0d rd=%0d pr=%0d wr=%0d", total_cycles, rd_cycles, pr_cycles, wr_cycles);

    // Run 2: three iterations, every phase acked after 2 cycles.
    do_start(16'd3);
    check("t2_clear_tx_done", tx_done, 0);
    check("t2_clear_total", total_cycles, 0);
    check("t2_clear_rd_done", rd_done, 0);
    for (int it = 0; it < 3; it++) begin
      run_phase(2, 0, 1'b0);
      check("t2_rd_done", rd_done, (it == 2) ? 1 : 0);
      run_phase(2, 1, 1'b0);
      check("t2_proc_done", processing_done, (it == 2) ? 1 : 0);
      run_phase(2, 2, 1'b0);
      check("t2_iter", iter_count, it + 1);
      check("t2_tx_done", tx_done, (it == 2) ? 1 : 0);
      check("t2_tx_req", tx_req, (it == 2) ? 0 : 1);
    end
    check("t2_total", total_cycles, 18);
    check("t2_rd_cycles", rd_cycles, 6);
    $display("run 2: iter=%0d total=%0d", iter_count, total_cycles);

    // Run 3: num_iters=0 acts as 1; 1-cycle RD with a stray wr_ack; start during PR.
    do_start(16'd0);
    rd_ack = 1'b1; wr_ack = 1'b1;
    step();
    rd_ack = 1'b0; wr_ack = 1'b0;
    check("t3_pr_start", pr_start, 1);
    check("t3_iter_stray_ack", iter_count, 0);
    check("t3_rd_done", rd_done, 1);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("t3_busy_after_start", busy, 1);
    check("t3_pr_cycles_mid", pr_cycles, 2);
    check("t3_rd_cycles_mid", rd_cycles, 1);
    pr_done = 1'b1;
    step();
    pr_done = 1'b0;
    check("t3_wr_req", wr_req, 1);
    run_phase(1, 2, 1'b0);
    check("t3_tx_done", tx_done, 1);
    check("t3_iter", iter_count, 1);
    check("t3_pr_cycles", pr_cycles, 3);
    check("t3_total", total_cycles, 5);
    $display("run 3: iter=%0d total=%0d", iter_count, total_cycles);

    // Run 4: abort on the 4th PR cycle together with pr_done.
    do_start(16'd2);
    run_phase(2, 0, 1'b0);
    repeat (3) step();
    abort = 1'b1; pr_done = 1'b1;
    step();
    abort = 1'b0; pr_done = 1'b0;
    check("t4_busy", busy, 0);
    check("t4_aborted", aborted, 1);
    check("t4_proc_done", processing_done, 0);
    check("t4_pr_cycles", pr_cycles, 4);
    check("t4_total", total_cycles, 6);
    for (int i = 0; i < 3; i++) begin
      check("t4_wr_req", wr_req, 0);
      step();
    end
    check("t4_aborted_hold", aborted, 1);
    $display("run 4: aborted=%0d pr=%0d", aborted, pr_cycles);

    // Run 5: 4-bit counters saturate during a 20-cycle PR.
    s_num_iters = 16'd1;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    run_phase(1, 0, 1'b1);
    run_phase(20, 1, 1'b1);
    check("t5_pr_sat", s_pr_cycles, 15);
    check("t5_total_sat", s_total_cycles, 15);
    check("t5_rd_cycles", s_rd_cycles, 1);
    run_phase(1, 2, 1'b1);
    check("t5_tx_done", s_tx_done, 1);
    check("t5_total_hold", s_total_cycles, 15);
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    check("t5_restart_pr", s_pr_cycles, 0);
    check("t5_restart_total", s_total_cycles, 0);
    check("t5_restart_tx_done", s_tx_done, 0);
    check("t5_restart_tx_req", s_tx_req, 1);
    $display("run 5: saturated pr=15 then cleared on restart");

    // Run 6: asynchronous reset in the middle of WR, then a clean run.
    do_start(16'd1);
    run_phase(1, 0, 1'b0);
    run_phase(1, 1, 1'b0);
    step();
    check("t6_wr_req_pre", wr_req, 1);
    #2 ARESETN = 1'b0;
    #1;
    check("t6_rst_ctl", {busy, wr_req, tx_req, pr_start}, 0);
    check("t6_rst_flags", {tx_done, rd_done, processing_done, wr_done, aborted}, 0);
    check("t6_rst_counters", {total_cycles, wr_cycles}, 0);
    check("t6_rst_iter", iter_count, 0);
    step();
    ARESETN = 1'b1;
    step();
    do_start(16'd1);
    run_phase(2, 0, 1'b0);
    run_phase(2, 1, 1'b0);
    run_phase(2, 2, 1'b0);
    check("t6_total", total_cycles, 6);
    check("t6_tx_done", tx_done, 1);
    check("t6_iter", iter_count, 1);
    check("t6_aborted", aborted, 0);
    $display("run 6: total=%0d after reset recovery", total_cycles);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
